// File: rtl/lcd_cmd_seq.sv
// Host-side command sequencer for the LCD controller: command FIFO, image streaming, result collection.
// Optional COLLECT watchdog is enabled by defining LCD_SEQ_TIMEOUT_EN.
module lcd_cmd_seq #(
  parameter int DEPTH     = 4,
  parameter int IMG_BYTES = 108,
  parameter int OUT_BYTES = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] h_cmd,
  input  logic       h_valid,
  output logic       h_ready,
  input  logic [7:0] img_data,
  input  logic       img_valid,
  output logic       img_ready,
  output logic [2:0] lcd_cmd,
  output logic       lcd_cmd_valid,
  output logic [7:0] lcd_datain,
  input  logic       lcd_busy,
  input  logic [7:0] lcd_dataout,
  input  logic       lcd_output_valid,
  output logic [7:0] res_data,
  output logic       res_valid,
  output logic       res_last,
  output logic       idle,
  output logic [1:0] err_code,
  input  logic       err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(IMG_BYTES);

  typedef enum logic [2:0] {IDLE, ISSUE, LOAD, WAIT_BUSY, COLLECT} state_t;

  state_t      state, state_nx;
  logic [2:0]  fifo_mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full, push, pop;
  logic [2:0]  head, cur_cmd;
  logic [LW-1:0] load_cnt;
  logic [4:0]  out_cnt, out_cnt_nx;
  logic        collect_valid;
  logic [1:0]  new_err;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head       = fifo_mem[rd_ptr[AW-1:0]];
  assign h_ready    = !fifo_full;
  assign push       = h_valid && !fifo_full && (h_cmd != 3'd7);
  assign idle       = (state == IDLE) && fifo_empty;
  assign lcd_cmd    = cur_cmd;

  assign collect_valid = (state == COLLECT) && lcd_output_valid;
  // Saturate so a runaway burst never wraps back onto the last-byte position
  assign out_cnt_nx = (collect_valid && out_cnt != 5'd31) ? out_cnt + 5'd1 : out_cnt;

`ifdef LCD_SEQ_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wd_cnt <= '0;
    else if (state == COLLECT && state_nx == COLLECT) wd_cnt <= wd_cnt + 1'b1;
    else wd_cnt <= '0;
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    pop           = 1'b0;
    new_err       = 2'd0;
    lcd_cmd_valid = 1'b0;
    img_ready     = 1'b0;
    lcd_datain    = 8'd0;
    case (state)
      IDLE: begin
        // A load is only started once the image source has data ready
        if (!fifo_empty && (head != 3'd0 || img_valid)) begin
          pop      = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        lcd_cmd_valid = 1'b1;
        state_nx      = (cur_cmd == 3'd0) ? LOAD : WAIT_BUSY;
      end
      LOAD: begin
        img_ready  = 1'b1;
        lcd_datain = img_valid ? img_data : 8'd0;
        if (!img_valid) new_err = 2'd3;
        if (load_cnt == LW'(IMG_BYTES - 1)) state_nx = COLLECT;
      end
      WAIT_BUSY: begin
        if (lcd_busy) state_nx = COLLECT;
        else begin
          new_err  = 2'd1;
          state_nx = IDLE;
        end
      end
      COLLECT: begin
        if (!lcd_busy) begin
          if (out_cnt_nx != 5'(OUT_BYTES)) new_err = 2'd2;
          state_nx = IDLE;
        end
`ifdef LCD_SEQ_TIMEOUT_EN
        else if (wd_cnt == WW'(TIMEOUT - 1)) begin
          new_err  = 2'd1;
          state_nx = IDLE;
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= h_cmd;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cur_cmd <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        cur_cmd <= head;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_cnt  <= '0;
      out_cnt   <= 5'd0;
      res_data  <= 8'd0;
      res_valid <= 1'b0;
      res_last  <= 1'b0;
    end else begin
      load_cnt  <= (state == LOAD) ? load_cnt + 1'b1 : '0;
      out_cnt   <= (state == COLLECT && state_nx == COLLECT) ? out_cnt_nx : 5'd0;
      res_valid <= collect_valid;
      res_last  <= collect_valid && (out_cnt_nx == 5'(OUT_BYTES));
      if (collect_valid) res_data <= lcd_dataout;
    end
  end

  // First error sticks; a fresh error beats a simultaneous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_code <= 2'd0;
    else if (new_err != 2'd0 && (err_code == 2'd0 || err_clr)) err_code <= new_err;
    else if (err_clr) err_code <= 2'd0;
  end

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Self-checking bench for lcd_cmd_seq with a behavioural LCD controller and image source.
// Expected issued commands and result bytes are queued when driven and compared when seen.
module tb_lcd_cmd_seq;
  localparam int IMG_BYTES = 108;
  localparam int OUT_BYTES = 16;

  logic       clk;
  logic       reset;
  logic [2:0] h_cmd;
  logic       h_valid;
  logic       h_ready;
  logic [7:0] img_data;
  logic       img_valid;
  logic       img_ready;
  logic [2:0] lcd_cmd;
  logic       lcd_cmd_valid;
  logic [7:0] lcd_datain;
  logic       lcd_busy;
  logic [7:0] lcd_dataout;
  logic       lcd_output_valid;
  logic [7:0] res_data;
  logic       res_valid;
  logic       res_last;
  logic       idle;
  logic [1:0] err_code;
  logic       err_clr;

  lcd_cmd_seq #(.DEPTH(4), .IMG_BYTES(IMG_BYTES), .OUT_BYTES(OUT_BYTES), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .h_cmd(h_cmd), .h_valid(h_valid), .h_ready(h_ready),
    .img_data(img_data), .img_valid(img_valid), .img_ready(img_ready),
    .lcd_cmd(lcd_cmd), .lcd_cmd_valid(lcd_cmd_valid), .lcd_datain(lcd_datain),
    .lcd_busy(lcd_busy), .lcd_dataout(lcd_dataout), .lcd_output_valid(lcd_output_valid),
    .res_data(res_data), .res_valid(res_valid), .res_last(res_last), .idle(idle),
    .err_code(err_code), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [2:0] exp_cmd[$];
  logic [8:0] exp_res[$];
  logic [8:0] mon_e;

  bit suppress_busy = 1'b0;
  bit img_hold      = 1'b1;
  int burst_len     = OUT_BYTES;
  int underrun_at   = -1;
  int wait_cnt, burst_left, burst_idx, load_idx;
  int load_cycles, res_seen;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed === expected) n_pass++;
    else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // Called at a falling edge; holds the request for one cycle
  task automatic push_cmd(input logic [2:0] c, output bit ok);
    h_cmd   = c;
    h_valid = 1'b1;
    ok      = h_ready;
    if (ok && c != 3'd7) exp_cmd.push_back(c);
    @(negedge clk);
    h_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (!(idle && !lcd_busy && exp_cmd.size() == 0 && exp_res.size() == 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output({tag, "_done"}, 32'(n < budget), 1);
  endtask

  task automatic pulse_clear();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
  endtask

  // LCD controller and image source model, driven on the falling edge
  initial begin
    lcd_busy = 1'b0; lcd_output_valid = 1'b0; lcd_dataout = 8'd0;
    img_valid = 1'b0; img_data = 8'd0;
    wait_cnt = 0; burst_left = 0; burst_idx = 0; load_idx = 0;
    forever begin
      @(negedge clk);
      lcd_output_valid = 1'b0;
      if (!reset) begin
        lcd_busy = 1'b0; wait_cnt = 0; burst_left = 0; load_idx = 0;
        img_valid = img_hold;
      end else begin
        if (lcd_cmd_valid) begin
          load_idx = 0;
          if (!suppress_busy) begin
            lcd_busy   = 1'b1;
            wait_cnt   = (lcd_cmd == 3'd0) ? IMG_BYTES + 2 : 3;
            burst_left = burst_len;
            burst_idx  = 0;
          end
        end else if (lcd_busy) begin
          if (wait_cnt > 0) wait_cnt--;
          else if (burst_left > 0) begin
            burst_idx++;
            lcd_dataout      = 8'($urandom);
            lcd_output_valid = 1'b1;
            exp_res.push_back({burst_idx == OUT_BYTES, lcd_dataout});
            burst_left--;
          end else lcd_busy = 1'b0;
        end
        if (img_ready) begin
          img_valid = (load_idx != underrun_at);
          img_data  = 8'($urandom);
          load_idx++;
          #1 check_output("lcd_datain", lcd_datain, img_valid ? img_data : 8'd0);
        end else begin
          img_valid = img_hold;
          img_data  = 8'($urandom);
        end
      end
    end
  end

  // Output monitor: pops the scoreboard whenever the DUT issues or forwards
  initial begin
    load_cycles = 0;
    res_seen    = 0;
    forever begin
      @(posedge clk);
      #1;
      if (lcd_cmd_valid) begin
        if (exp_cmd.size() == 0) check_output("unexpected_issue", 1, 0);
        else check_output("issue_cmd", lcd_cmd, exp_cmd.pop_front());
      end
      if (img_ready) load_cycles++;
      if (res_valid) begin
        res_seen++;
        if (exp_res.size() == 0) check_output("unexpected_res", 1, 0);
        else begin
          mon_e = exp_res.pop_front();
          check_output("res_data", res_data, mon_e[7:0]);
          check_output("res_last", res_last, mon_e[8]);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit ok;
    int accepted, n;
    logic [2:0] seq [4];
    seq[0] = 3'd1; seq[1] = 3'd3; seq[2] = 3'd3; seq[3] = 3'd5;

    reset = 1'b0; h_valid = 1'b0; h_cmd = 3'd0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    check_output("rst_h_ready", h_ready, 1);
    check_output("rst_idle", idle, 1);
    check_output("rst_cmd_valid", lcd_cmd_valid, 0);
    check_output("rst_img_ready", img_ready, 0);
    check_output("rst_res_valid", res_valid, 0);
    check_output("rst_lcd_cmd", lcd_cmd, 0);
    check_output("rst_datain", lcd_datain, 0);
    check_output("rst_err", err_code, 0);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] load then zoom-fit");
    load_cycles = 0; res_seen = 0;
    push_cmd(3'd0, ok);
    check_output("t1_accept", ok, 1);
    wait_done("t1", 600);
    check_output("t1_load_cycles", load_cycles, IMG_BYTES);
    check_output("t1_res_count", res_seen, OUT_BYTES);
    check_output("t1_err", err_code, 0);
    check_output("t1_idle", idle, 1);

    $display("[TB] queued zoom/shift sequence");
    res_seen = 0;
    for (int i = 0; i < 4; i++) begin
      push_cmd(seq[i], ok);
      check_output("t2_h_ready", ok, 1);
    end
    wait_done("t2", 600);
    check_output("t2_res_count", res_seen, 4 * OUT_BYTES);
    check_output("t2_err", err_code, 0);

    $display("[TB] fifo overflow during load");
    push_cmd(3'd0, ok);
    n = 0;
    while (!img_ready && n < 20) begin @(negedge clk); n++; end
    check_output("t3_load_started", img_ready, 1);
    accepted = 0;
    for (int i = 1; i <= 6; i++) begin
      push_cmd(3'(i), ok);
      accepted += int'(ok);
    end
    check_output("t3_accepted", accepted, 4);
    check_output("t3_h_ready_low", h_ready, 0);
    for (int i = 5; i <= 6; i++) begin
      n = 0;
      do begin push_cmd(3'(i), ok); n++; end while (!ok && n < 500);
      check_output("t3_late_accept", ok, 1);
    end
    wait_done("t3", 2000);
    check_output("t3_err", err_code, 0);

    $display("[TB] image underrun");
    underrun_at = 50; load_cycles = 0;
    push_cmd(3'd0, ok);
    wait_done("t4", 600);
    underrun_at = -1;
    check_output("t4_load_cycles", load_cycles, IMG_BYTES);
    check_output("t4_err", err_code, 3);
    pulse_clear();
    check_output("t4_err_clr", err_code, 0);

    $display("[TB] short burst");
    burst_len = OUT_BYTES - 1;
    push_cmd(3'd2, ok);
    wait_done("t4b", 300);
    burst_len = OUT_BYTES;
    check_output("t4b_err", err_code, 2);

    $display("[TB] illegal command and missing busy");
    push_cmd(3'd7, ok);
    check_output("t5_cmd7_ready", ok, 1);
    repeat (5) @(negedge clk);
    check_output("t5_cmd7_idle", idle, 1);
    suppress_busy = 1'b1;
    push_cmd(3'd2, ok);
    wait_done("t5a", 50);
    check_output("t5_err_sticky", err_code, 2);
    pulse_clear();
    check_output("t5_err_clr0", err_code, 0);
    push_cmd(3'd2, ok);
    wait_done("t5b", 50);
    suppress_busy = 1'b0;
    check_output("t5_err_busy", err_code, 1);
    check_output("t5_idle", idle, 1);
    pulse_clear();
    check_output("t5_err_clr1", err_code, 0);

    $display("[TB] reset mid-burst");
    res_seen = 0;
    push_cmd(3'd4, ok);
    n = 0;
    while (res_seen < 8 && n < 100) begin @(negedge clk); n++; end
    check_output("t6_reach8", res_seen, 8);
    reset = 1'b0;
    #1;
    check_output("t6_h_ready", h_ready, 1);
    check_output("t6_idle", idle, 1);
    check_output("t6_res_valid", res_valid, 0);
    check_output("t6_res_last", res_last, 0);
    check_output("t6_res_data", res_data, 0);
    check_output("t6_cmd_valid", lcd_cmd_valid, 0);
    check_output("t6_lcd_cmd", lcd_cmd, 0);
    check_output("t6_img_ready", img_ready, 0);
    check_output("t6_err", err_code, 0);
    repeat (2) @(negedge clk);
    exp_res.delete();
    exp_cmd.delete();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_output("t6_fifo_empty", idle, 1);
    res_seen = 0;
    push_cmd(3'd1, ok);
    wait_done("t6_recover", 300);
    check_output("t6_recover_count", res_seen, OUT_BYTES);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
